// File: rtl/cnt_pwm_ctrl.sv
// PWM generator locked to an upstream free-running counter: one PWM period per
// counter wrap, duty updates double-buffered to period boundaries, count-sequence monitor.
module cnt_pwm_ctrl #(
    parameter int CNT_W = 4,
    parameter int PER_W = 8
) (
    input  logic             clk2,
    input  logic             rstn,
    input  logic [CNT_W-1:0] cnt_in,
    input  logic             en,
    input  logic [CNT_W:0]   duty_in,
    input  logic             duty_valid,
    output logic             duty_ready,
    output logic             pwm_out,
    output logic             period_pulse,
    output logic [PER_W-1:0] period_cnt,
    output logic             seq_err,
    output logic [1:0]       state_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam logic [CNT_W:0]   DUTY_MAX = {1'b1, {CNT_W{1'b0}}};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = 1;
    localparam logic [PER_W-1:0] PER_MAX  = {PER_W{1'b1}};
    localparam logic [PER_W-1:0] PER_ONE  = 1;

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] prev_cnt;
    logic             prev_vld;
    logic [CNT_W:0]   duty_act;
    logic [CNT_W:0]   shadow;
    logic             shadow_vld;

    logic             wrap;
    logic             active;
    logic             accept;
    logic             apply_shadow;
    logic             enter_armed;
    logic             seq_bad;
    logic [CNT_W:0]   duty_sat;
    logic [CNT_W:0]   duty_eff;
    logic             pwm_next;
    logic             pulse_next;

    assign wrap         = prev_vld && (prev_cnt == CNT_MAX) && (cnt_in == '0);
    assign active       = (state == RUN) || (state == DRAIN);
    assign accept       = duty_valid && duty_ready;
    assign apply_shadow = active && wrap && shadow_vld;
    assign enter_armed  = (state == IDLE) && (next_state == ARMED);
    assign seq_bad      = (state != IDLE) && prev_vld && (cnt_in != prev_cnt + CNT_ONE);
    assign duty_sat     = (duty_in > DUTY_MAX) ? DUTY_MAX : duty_in;
    // The first cycle of a new period must already see the promoted duty value.
    assign duty_eff     = apply_shadow ? shadow : duty_act;

    always_ff @(posedge clk2) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        // NOTE: default first so no path through the case leaves next_state unassigned (no latch).
        next_state = state;
        case (state)
            IDLE:    if (en) next_state = ARMED;
            ARMED:   if (!en) next_state = IDLE;
                     else if (cnt_in == '0) next_state = RUN;
            RUN:     if (!en) next_state = DRAIN;
            DRAIN:   if (en) next_state = RUN;
                     else if (wrap) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Gating on next_state lets the ARMED->RUN cycle (cnt_in==0) drive a full
    // period and forces the DRAIN->IDLE cycle low.
    always_comb begin
        pwm_next   = 1'b0;
        pulse_next = 1'b0;
        if (next_state == RUN || next_state == DRAIN) begin
            pwm_next = ({1'b0, cnt_in} < duty_eff);
        end
        if (active && wrap) begin
            pulse_next = 1'b1;
        end
    end

    assign duty_ready = !shadow_vld;
    assign state_o    = state;

    always_ff @(posedge clk2) begin
        if (!rstn) begin
            prev_cnt     <= '0;
            prev_vld     <= 1'b0;
            duty_act     <= '0;
            shadow       <= '0;
            shadow_vld   <= 1'b0;
            pwm_out      <= 1'b0;
            period_pulse <= 1'b0;
            period_cnt   <= '0;
            seq_err      <= 1'b0;
        end else begin
            prev_cnt     <= cnt_in;
            prev_vld     <= 1'b1;
            pwm_out      <= pwm_next;
            period_pulse <= pulse_next;

            if (enter_armed) begin
                period_cnt <= '0;
                seq_err    <= 1'b0;
            end else begin
                if (pulse_next && period_cnt != PER_MAX) period_cnt <= period_cnt + PER_ONE;
                if (seq_bad) seq_err <= 1'b1;
            end

            if (apply_shadow) begin
                duty_act   <= shadow;
                shadow_vld <= 1'b0;
            end
            // A handshake can only fire with the shadow empty, so it never races apply_shadow.
            if (accept) begin
                if (active) begin
                    shadow     <= duty_sat;
                    shadow_vld <= 1'b1;
                end else begin
                    duty_act <= duty_sat;
                end
            end
        end
    end

endmodule

// File: tb/tb_cnt_pwm_ctrl.sv
// Bench for cnt_pwm_ctrl: directed vector table, hand-written period sequences and
// randomized traffic, all compared against a period-level behavioural model.
module tb_cnt_pwm_ctrl;

    logic       clk2 = 1'b0;
    logic       rstn;
    logic [3:0] cnt_in;
    logic       en;
    logic [4:0] duty_in;
    logic       duty_valid;
    logic       duty_ready;
    logic       pwm_out;
    logic       period_pulse;
    logic [7:0] period_cnt;
    logic       seq_err;
    logic [1:0] state_o;

    int n_checks = 0;
    int n_errors = 0;
    int cnt_r    = 0;

    cnt_pwm_ctrl dut (
        .clk2         (clk2),
        .rstn         (rstn),
        .cnt_in       (cnt_in),
        .en           (en),
        .duty_in      (duty_in),
        .duty_valid   (duty_valid),
        .duty_ready   (duty_ready),
        .pwm_out      (pwm_out),
        .period_pulse (period_pulse),
        .period_cnt   (period_cnt),
        .seq_err      (seq_err),
        .state_o      (state_o)
    );

    always #5 clk2 = ~clk2;

    // Reference model: mode 0 idle, 1 armed, 2 run, 3 drain; pending duty kept in a queue.
    int m_mode = 0, m_pwm = 0, m_pulse = 0, m_pc = 0, m_err = 0, m_duty = 0;
    int m_prev = 0, m_have_prev = 0, m_ready = 1;
    int pend[$];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic model_step();
        int c, nmode, dcur, dsat, wrapped, running, take;
        if (!rstn) begin
            m_mode = 0; m_pwm = 0; m_pulse = 0; m_pc = 0; m_err = 0; m_duty = 0;
            m_prev = 0; m_have_prev = 0;
            pend.delete();
        end else begin
            c       = int'(cnt_in);
            wrapped = (m_have_prev != 0 && m_prev == 15 && c == 0) ? 1 : 0;
            running = (m_mode >= 2) ? 1 : 0;
            take    = (duty_valid && pend.size() == 0) ? 1 : 0;
            dsat    = (int'(duty_in) > 16) ? 16 : int'(duty_in);
            dcur    = m_duty;
            if (running != 0 && wrapped != 0 && pend.size() != 0) dcur = pend.pop_front();
            case (m_mode)
                0:       nmode = en ? 1 : 0;
                1:       nmode = !en ? 0 : (c == 0 ? 2 : 1);
                2:       nmode = en ? 2 : 3;
                default: nmode = en ? 2 : (wrapped != 0 ? 0 : 3);
            endcase
            m_pwm   = (nmode >= 2 && c < dcur) ? 1 : 0;
            m_pulse = (running != 0 && wrapped != 0) ? 1 : 0;
            if (m_mode == 0 && nmode == 1) begin
                m_pc  = 0;
                m_err = 0;
            end else begin
                if (m_pulse != 0 && m_pc < 255) m_pc++;
                if (m_mode != 0 && m_have_prev != 0 && c != (m_prev + 1) % 16) m_err = 1;
            end
            m_duty = dcur;
            if (take != 0) begin
                if (running != 0) pend.push_back(dsat);
                else m_duty = dsat;
            end
            m_mode = nmode;
            m_prev = c;
            m_have_prev = 1;
        end
        m_ready = (pend.size() == 0) ? 1 : 0;
    endtask

    task automatic compare_all();
        check("state_o", int'(state_o), m_mode);
        check("pwm_out", int'(pwm_out), m_pwm);
        check("period_pulse", int'(period_pulse), m_pulse);
        check("period_cnt", int'(period_cnt), m_pc);
        check("seq_err", int'(seq_err), m_err);
        check("duty_ready", int'(duty_ready), m_ready);
    endtask

    // Inputs are set at the negedge; outputs are sampled 1 time unit after the posedge.
    task automatic cycle();
        model_step();
        @(posedge clk2);
        #1;
        compare_all();
        @(negedge clk2);
    endtask

    task automatic next_cnt();
        cnt_r  = (cnt_r + 1) % 16;
        cnt_in = 4'(cnt_r);
        cycle();
    endtask

    task automatic run_period(input int wr_at, input int wr_val, output int highs, output int pulses);
        highs = 0;
        pulses = 0;
        for (int i = 0; i < 16; i++) begin
            duty_valid = (i == wr_at);
            duty_in    = 5'(wr_val);
            next_cnt();
            highs  += int'(pwm_out);
            pulses += int'(period_pulse);
        end
        duty_valid = 1'b0;
    endtask

    typedef struct {
        logic       rstn;
        logic       en;
        logic [3:0] cnt;
        logic       dv;
        logic [4:0] din;
        logic [1:0] st;
        logic       pwm;
        logic       rdy;
        logic       pul;
        logic       err;
        logic [7:0] pc;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic e, input int c, input logic dv,
                                input int d, input int st, input logic pwm, input logic rdy);
        vec_t v;
        v.rstn = r; v.en = e; v.cnt = 4'(c); v.dv = dv; v.din = 5'(d);
        v.st = 2'(st); v.pwm = pwm; v.rdy = rdy; v.pul = 1'b0; v.err = 1'b0; v.pc = 8'd0;
        return v;
    endfunction

    initial begin
        vec_t vecs[12];
        int   highs, pulses;

        rstn = 1'b0; en = 1'b0; cnt_in = '0; duty_in = '0; duty_valid = 1'b0;

        // Reset with counter running, then write duty 5 in IDLE and arm near a wrap.
        vecs[0]  = mk(0, 0,  3, 0, 0, 0, 0, 1);
        vecs[1]  = mk(0, 1,  4, 1, 9, 0, 0, 1);
        vecs[2]  = mk(1, 0, 13, 1, 5, 0, 0, 1);
        vecs[3]  = mk(1, 1, 14, 0, 0, 1, 0, 1);
        vecs[4]  = mk(1, 1, 15, 0, 0, 1, 0, 1);
        vecs[5]  = mk(1, 1,  0, 0, 0, 2, 1, 1);
        vecs[6]  = mk(1, 1,  1, 0, 0, 2, 1, 1);
        vecs[7]  = mk(1, 1,  2, 0, 0, 2, 1, 1);
        vecs[8]  = mk(1, 1,  3, 0, 0, 2, 1, 1);
        vecs[9]  = mk(1, 1,  4, 0, 0, 2, 1, 1);
        vecs[10] = mk(1, 1,  5, 0, 0, 2, 0, 1);
        vecs[11] = mk(1, 1,  6, 0, 0, 2, 0, 1);

        for (int i = 0; i < 12; i++) begin
            rstn = vecs[i].rstn; en = vecs[i].en; duty_valid = vecs[i].dv; duty_in = vecs[i].din;
            cnt_r = int'(vecs[i].cnt);
            cnt_in = vecs[i].cnt;
            cycle();
            check($sformatf("vec%0d.state", i), int'(state_o), int'(vecs[i].st));
            check($sformatf("vec%0d.pwm", i), int'(pwm_out), int'(vecs[i].pwm));
            check($sformatf("vec%0d.ready", i), int'(duty_ready), int'(vecs[i].rdy));
            check($sformatf("vec%0d.pulse", i), int'(period_pulse), int'(vecs[i].pul));
            check($sformatf("vec%0d.seq_err", i), int'(seq_err), int'(vecs[i].err));
            check($sformatf("vec%0d.period_cnt", i), int'(period_cnt), int'(vecs[i].pc));
        end
        duty_valid = 1'b0;

        // Full period at duty 5.
        while (cnt_r != 15) next_cnt();
        run_period(-1, 0, highs, pulses);
        check("duty5.highs", highs, 5);
        check("duty5.pulses", pulses, 1);

        // Mid-period write is held in the shadow until the next wrap.
        run_period(3, 12, highs, pulses);
        check("shadow.old_highs", highs, 5);
        check("shadow.ready_low", int'(duty_ready), 0);
        run_period(-1, 0, highs, pulses);
        check("shadow.new_highs", highs, 12);
        check("shadow.ready_back", int'(duty_ready), 1);

        // Write coincident with wrap lands one period later.
        run_period(0, 3, highs, pulses);
        check("wrapwr.same_period", highs, 12);
        run_period(-1, 0, highs, pulses);
        check("wrapwr.next_period", highs, 3);

        // Duty extremes and saturation.
        run_period(5, 0, highs, pulses);
        run_period(-1, 0, highs, pulses);
        check("duty0.highs", highs, 0);
        run_period(5, 16, highs, pulses);
        run_period(-1, 0, highs, pulses);
        check("duty16.highs", highs, 16);
        run_period(5, 31, highs, pulses);
        run_period(-1, 0, highs, pulses);
        check("duty31.highs", highs, 16);
        run_period(5, 5, highs, pulses);
        run_period(-1, 0, highs, pulses);
        check("duty5b.highs", highs, 5);

        // Drop en at cnt 7: drain the period, go idle at wrap with pwm low.
        highs = 0;
        for (int i = 0; i < 16; i++) begin
            en = (((cnt_r + 1) % 16) < 7);
            next_cnt();
            highs += int'(pwm_out);
            if (cnt_r == 7) check("drain.state", int'(state_o), 3);
        end
        check("drain.highs", highs, 5);
        next_cnt();
        check("drain.idle", int'(state_o), 0);
        check("drain.pwm_low", int'(pwm_out), 0);
        check("drain.pulse", int'(period_pulse), 1);

        // Re-arm, then drop en and restore it before the wrap: no gap.
        en = 1'b1;
        while (cnt_r != 15) next_cnt();
        highs = 0;
        for (int i = 0; i < 16; i++) begin
            en = !(((cnt_r + 1) % 16) >= 7 && ((cnt_r + 1) % 16) < 10);
            next_cnt();
            highs += int'(pwm_out);
            if (cnt_r == 9) check("bounce.drain", int'(state_o), 3);
            if (cnt_r == 10) check("bounce.run", int'(state_o), 2);
        end
        check("bounce.highs", highs, 5);
        run_period(-1, 0, highs, pulses);
        check("bounce.next_highs", highs, 5);

        // Skip 3->5: sticky seq_err, PWM keeps running.
        highs = 0;
        for (int i = 0; i < 15; i++) begin
            cnt_r  = (cnt_r == 3) ? 5 : (cnt_r + 1) % 16;
            cnt_in = 4'(cnt_r);
            cycle();
            highs += int'(pwm_out);
            if (cnt_r == 5) check("skip.seq_err", int'(seq_err), 1);
        end
        check("skip.highs", highs, 4);
        check("skip.sticky", int'(seq_err), 1);
        check("skip.state", int'(state_o), 2);

        // Re-arm clears seq_err and period_cnt.
        en = 1'b0;
        for (int i = 0; i < 17; i++) next_cnt();
        check("rearm.idle", int'(state_o), 0);
        check("rearm.err_held", int'(seq_err), 1);
        en = 1'b1;
        next_cnt();
        check("rearm.armed", int'(state_o), 1);
        check("rearm.seq_err", int'(seq_err), 0);
        check("rearm.period_cnt", int'(period_cnt), 0);

        // 300 periods saturate period_cnt.
        for (int i = 0; i < 16 * 302; i++) next_cnt();
        check("sat.period_cnt", int'(period_cnt), 255);

        // Mid-operation reset.
        rstn = 1'b0;
        next_cnt();
        check("midrst.state", int'(state_o), 0);
        check("midrst.period_cnt", int'(period_cnt), 0);
        check("midrst.pwm", int'(pwm_out), 0);
        check("midrst.ready", int'(duty_ready), 1);
        rstn = 1'b1;

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            rstn       = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 39) == 0) en = ~en;
            duty_valid = ($urandom_range(0, 3) == 0);
            duty_in    = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 59) == 0) cnt_r = $urandom_range(0, 15);
            else cnt_r = (cnt_r + 1) % 16;
            cnt_in = 4'(cnt_r);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
